// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//
// Scans an 8x8 RGB LED matrix one row at a time from a double-buffered frame
// store. Game logic fills the back bank row by row and then requests a swap.
// The swap is deferred to the next frame boundary, which is the 7->0 row wrap,
// so a displayed frame is never mixed from two banks.
//
// Parameters:
//   ROW_DIV  clock cycles each row is held (2..65535)
//   BLANK    cycles at the start of each row with all colours off (< ROW_DIV)
//
// Ports:
//   CLK           system clock, rising edge
//   clear         asynchronous active-high reset
//   wr_en         write strobe for the back bank
//   wr_row        row written when wr_en=1
//   wr_r/g/b      active-low colour patterns for wr_row
//   swap_req      single-cycle request to exchange front and back banks
//   swap_pending  a swap is latched and waiting for the frame boundary
//   swap_ack      one-cycle pulse on the edge where the swap takes effect
//   frame_start   one-cycle pulse when the row counter wraps 7->0
//   DATA_R/G/B    active-low column drives
//   COMM          index of the selected row
//   EN            matrix driver enable
// -----------------------------------------------------------------------------
module led_matrix_scanner #(
  parameter int ROW_DIV = 5000,
  parameter int BLANK   = 2
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic [2:0] COMM,
  output logic       EN
);

  localparam logic [15:0] CNT_MAX   = 16'(ROW_DIV - 1);
  localparam logic [15:0] BLANK_CNT = 16'(BLANK);

  // Two banks of 8 rows, each row packed as {R, G, B}
  logic [23:0] bank_q [2][8];
  logic [23:0] bank_d [2][8];

  logic        fsel_q, fsel_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] cnt_q, cnt_d;
  logic        swap_pending_q, swap_pending_d;
  logic        swap_ack_q, swap_ack_d;
  logic        frame_start_q, frame_start_d;
  logic [23:0] data_q, data_d;
  logic [2:0]  comm_q, comm_d;
  logic        en_q, en_d;

  logic        row_end;
  logic        wrap;
  logic        swap_now;
  logic [23:0] front_row;

  always_comb begin
    row_end  = (cnt_q == CNT_MAX);
    wrap     = row_end && (row_q == 3'd7);
    swap_now = wrap && swap_pending_q;

    cnt_d = row_end ? 16'd0 : cnt_q + 16'd1;
    row_d = row_end ? row_q + 3'd1 : row_q;

    frame_start_d = wrap;
    swap_ack_d    = swap_now;
    fsel_d        = fsel_q ^ swap_now;

    // On the wrap edge the old pending request is consumed; a request arriving
    // on that same edge becomes the pending request for the next frame.
    if (wrap) begin
      swap_pending_d = swap_req;
    end else begin
      swap_pending_d = swap_pending_q | swap_req;
    end

    // Writes always target the bank that is back before this edge, so a write
    // on the swap edge lands in the bank that is about to become front.
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[~fsel_q][wr_row] = {wr_r, wr_g, wr_b};
    end

    // Reading the post-write bank keeps a same-edge write visible immediately.
    front_row = bank_d[fsel_d][row_d];
    data_d    = (cnt_d < BLANK_CNT) ? 24'hFF_FFFF : front_row;
    comm_d    = row_d;
    en_d      = 1'b1;
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          bank_q[b][r] <= 24'hFF_FFFF;
        end
      end
      fsel_q         <= 1'b0;
      row_q          <= 3'd0;
      cnt_q          <= 16'd0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      data_q         <= 24'hFF_FFFF;
      comm_q         <= 3'd0;
      en_q           <= 1'b0;
    end else begin
      bank_q         <= bank_d;
      fsel_q         <= fsel_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      swap_pending_q <= swap_pending_d;
      swap_ack_q     <= swap_ack_d;
      frame_start_q  <= frame_start_d;
      data_q         <= data_d;
      comm_q         <= comm_d;
      en_q           <= en_d;
    end
  end

  assign swap_pending = swap_pending_q;
  assign swap_ack     = swap_ack_q;
  assign frame_start  = frame_start_q;
  assign DATA_R       = data_q[23:16];
  assign DATA_G       = data_q[15:8];
  assign DATA_B       = data_q[7:0];
  assign COMM         = comm_q;
  assign EN           = en_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
//
// Directed bench for led_matrix_scanner with ROW_DIV=8, BLANK=2. The stimulus
// process drives inputs on the falling edge and, after each rising edge, pushes
// the hand-derived expected outputs for that cycle into a scoreboard queue.
// An independent monitor pops and compares entries shortly after each falling
// edge.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

  localparam int ROW_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 8 * ROW_DIV;

  logic       CLK = 1'b0;
  logic       clear;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_r, wr_g, wr_b;
  logic       swap_req;
  logic       swap_pending, swap_ack, frame_start;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [2:0] COMM;
  logic       EN;

  led_matrix_scanner #(.ROW_DIV(ROW_DIV), .BLANK(BLANK)) dut (
    .CLK          (CLK),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_r         (wr_r),
    .wr_g         (wr_g),
    .wr_b         (wr_b),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_ack     (swap_ack),
    .frame_start  (frame_start),
    .DATA_R       (DATA_R),
    .DATA_G       (DATA_G),
    .DATA_B       (DATA_B),
    .COMM         (COMM),
    .EN           (EN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    time         t;
    string       name;
    logic [2:0]  comm;
    logic [23:0] rgb;
    logic        en;
    logic        fs;
    logic        ack;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int    errors = 0;
  int    checks = 0;
  int    k;
  time   neg_time;
  string phase;

  // Bench-side picture of what each bank should hold and which one is front
  logic [23:0] exp_bank [2][8];
  logic        exp_fsel;
  logic        exp_pend;
  logic        exp_ack;

  task automatic step();
    @(negedge CLK);
    neg_time = $time;
  endtask

  task automatic reset_expectations();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) begin
        exp_bank[b][r] = 24'hFF_FFFF;
      end
    end
    exp_fsel = 1'b0;
    exp_pend = 1'b0;
    exp_ack  = 1'b0;
    k        = 0;
  endtask

  task automatic push_reset_exp(input string nm);
    exp_t e;
    e.t    = neg_time;
    e.name = nm;
    e.comm = 3'd0;
    e.rgb  = 24'hFF_FFFF;
    e.en   = 1'b0;
    e.fs   = 1'b0;
    e.ack  = 1'b0;
    e.pend = 1'b0;
    sb.push_back(e);
  endtask

  // Advance one rising edge and record what the outputs must show after it
  task automatic apply_stimulus();
    exp_t e;
    int   cnt;
    int   row;
    step();
    k   = k + 1;
    cnt = k % ROW_DIV;
    row = (k / ROW_DIV) % 8;
    e.t    = neg_time;
    e.name = phase;
    e.comm = 3'(row);
    e.rgb  = (cnt < BLANK) ? 24'hFF_FFFF : exp_bank[exp_fsel][row];
    e.en   = 1'b1;
    e.fs   = ((k % FRAME) == 0);
    e.ack  = exp_ack;
    e.pend = exp_pend;
    sb.push_back(e);
  endtask

  task automatic run_to(input int target);
    while (k < target) apply_stimulus();
  endtask

  task automatic check_output(input exp_t e);
    logic [23:0] act_rgb;
    act_rgb = {DATA_R, DATA_G, DATA_B};
    checks++;
    if (COMM !== e.comm || act_rgb !== e.rgb || EN !== e.en ||
        frame_start !== e.fs || swap_ack !== e.ack || swap_pending !== e.pend) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got comm=%0d rgb=%h en=%b fs=%b ack=%b pend=%b, expected comm=%0d rgb=%h en=%b fs=%b ack=%b pend=%b",
               e.name, $time, COMM, act_rgb, EN, frame_start, swap_ack, swap_pending,
               e.comm, e.rgb, e.en, e.fs, e.ack, e.pend);
    end
  endtask

  // Monitor: compares every scoreboard entry belonging to this falling edge
  always @(negedge CLK) begin
    #2;
    while (sb.size() > 0 && sb[0].t < $time - 2) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s stale entry t=%0t: got unchecked, expected check at its own edge",
               mon_e.name, mon_e.t);
    end
    while (sb.size() > 0 && sb[0].t == $time - 2) begin
      mon_e = sb.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear    = 1'b1;
    wr_en    = 1'b0;
    wr_row   = 3'd0;
    wr_r     = 8'h00;
    wr_g     = 8'h00;
    wr_b     = 8'h00;
    swap_req = 1'b0;
    reset_expectations();

    phase = "reset";
    step();
    push_reset_exp("reset");
    #3 clear = 1'b0;

    // Idle scan over a full frame and into the next
    phase = "idle_scan";
    run_to(72);

    // Write back-bank row 3, request swap mid-row 2, swap at next wrap
    phase = "write_swap";
    wr_en  = 1'b1;
    wr_row = 3'd3;
    wr_r   = 8'h0F;
    wr_g   = 8'hFF;
    wr_b   = 8'hF0;
    exp_bank[~exp_fsel][3] = 24'h0F_FFF0;
    apply_stimulus();
    wr_en = 1'b0;
    run_to(83);
    swap_req = 1'b1;
    exp_pend = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(127);
    exp_ack  = 1'b1;
    exp_pend = 1'b0;
    exp_fsel = 1'b1;
    apply_stimulus();
    exp_ack = 1'b0;

    // Two requests in one frame coalesce into one swap
    phase = "coalesce";
    run_to(139);
    swap_req = 1'b1;
    exp_pend = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(159);
    swap_req = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(191);
    exp_ack  = 1'b1;
    exp_pend = 1'b0;
    exp_fsel = 1'b0;
    apply_stimulus();
    exp_ack = 1'b0;

    // Request on the wrap edge with nothing pending waits one more frame
    phase = "req_on_wrap";
    run_to(255);
    swap_req = 1'b1;
    exp_pend = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(319);
    exp_ack  = 1'b1;
    exp_pend = 1'b0;
    exp_fsel = 1'b1;
    apply_stimulus();
    exp_ack = 1'b0;

    // Write on the exact swap edge lands in the new front bank
    phase = "write_on_swap";
    run_to(329);
    swap_req = 1'b1;
    exp_pend = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(383);
    wr_en  = 1'b1;
    wr_row = 3'd5;
    wr_r   = 8'h00;
    wr_g   = 8'h00;
    wr_b   = 8'h00;
    exp_bank[~exp_fsel][5] = 24'h00_0000;
    exp_ack  = 1'b1;
    exp_pend = 1'b0;
    exp_fsel = 1'b0;
    apply_stimulus();
    wr_en   = 1'b0;
    exp_ack = 1'b0;
    run_to(431);

    // Request on the wrap edge while one is pending: swap and stay pending
    phase = "req_on_wrap_pending";
    run_to(439);
    swap_req = 1'b1;
    exp_pend = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    run_to(447);
    swap_req = 1'b1;
    exp_ack  = 1'b1;
    exp_fsel = 1'b1;
    apply_stimulus();
    swap_req = 1'b0;
    exp_ack  = 1'b0;
    run_to(483);

    // Asynchronous clear mid-row 4 with a swap pending
    phase = "clear";
    step();
    clear = 1'b1;
    #1;
    push_reset_exp("clear_async");
    step();
    push_reset_exp("clear_hold");
    #3 clear = 1'b0;
    reset_expectations();

    phase = "after_clear";
    run_to(72);

    repeat (3) step();
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
